axil_aw_skid_slice: RTL and testbench

- Two-entry skid buffer for the AXI-Lite write-address (AW) channel.
- Sits directly downstream of an AXI-Lite master's AW port and feeds the slave-side address decoder; the master-facing side must pass the team's AW protocol checker unmodified.
- Fully registers both the forward path (VALID/ADDR/PROT) and the backward path (READY), breaking timing while sustaining one transfer per cycle.
- Adds a downstream stall monitor with a sticky error flag.

---
 rtl/axil_pkg.sv | 25 ++
 rtl/axil_stall_mon.sv | 58 +++++
 rtl/axil_aw_skid_slice.sv | 134 +++++++++++++
 tb/tb_axil_aw_skid_slice.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared AXI-Lite types and constants. Holds the default
//                address/protection widths, a packed AW payload struct and
//                the occupancy codes used by the AW skid slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_PROT_W = 3;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [AXIL_PROT_W-1:0] prot;
  } axil_aw_t;

  // Occupancy doubles as the slice state encoding.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/axil_stall_mon.sv
`default_nettype none
// ============================================================================
//  Module      : axil_stall_mon
//  Description : Channel stall monitor. Counts consecutive edges on which
//                valid is high and ready is low; sets a sticky error flag
//                once the count reaches MAXWAIT. Channel-agnostic, so it can
//                sit on any AXI-Lite handshake.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                valid     - channel valid
//                ready     - channel ready
//                stall_err - sticky stall error, cleared only by reset
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_stall_mon #(
  parameter int MAXWAIT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  output logic stall_err
);

  localparam int               CNT_W   = $clog2(MAXWAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXWAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  always_comb begin
    cnt_d = cnt_q;
    // Any completed handshake or idle channel restarts the stall window.
    if (!valid || ready) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Flag is raised on the same edge the count reaches MAXWAIT.
    err_d = err_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stall_err = err_q;

endmodule
`default_nettype wire

// File: rtl/axil_aw_skid_slice.sv
`default_nettype none
// ============================================================================
//  Module      : axil_aw_skid_slice
//  Description : Two-entry skid buffer for the AXI-Lite AW channel. Both the
//                forward path (valid/addr/prot) and the backward ready are
//                driven straight from flops, while still sustaining one
//                transfer per cycle. Includes a downstream stall monitor.
//  Ports       : AXI_ACLK    - clock, rising edge
//                AXI_ARESETN - asynchronous active-low reset
//                S_AW*       - upstream (master-facing) AW channel
//                M_AW*       - downstream (decoder-facing) AW channel
//                occupancy   - entries held (0, 1 or 2)
//                stall_err   - sticky downstream stall error
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_aw_skid_slice
  import axil_pkg::*;
#(
  parameter int ADDR_W  = AXIL_ADDR_W,
  parameter int PROT_W  = AXIL_PROT_W,
  parameter int MAXWAIT = 5
) (
  input  logic              AXI_ACLK,
  input  logic              AXI_ARESETN,
  input  logic [ADDR_W-1:0] S_AWADDR,
  input  logic [PROT_W-1:0] S_AWPROT,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  output logic [ADDR_W-1:0] M_AWADDR,
  output logic [PROT_W-1:0] M_AWPROT,
  output logic              M_AWVALID,
  input  logic              M_AWREADY,
  output logic [1:0]        occupancy,
  output logic              stall_err
);

  logic [1:0]        occ_q,       occ_d;
  logic              s_ready_q,   s_ready_d;
  logic              m_valid_q,   m_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [PROT_W-1:0] out_prot_q,  out_prot_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [PROT_W-1:0] skid_prot_q, skid_prot_d;

  logic s_fire;
  logic m_fire;

  assign s_fire = S_AWVALID & s_ready_q;
  assign m_fire = m_valid_q & M_AWREADY;

  always_comb begin
    occ_d       = occ_q;
    out_addr_d  = out_addr_q;
    out_prot_d  = out_prot_q;
    skid_addr_d = skid_addr_q;
    skid_prot_d = skid_prot_q;

    case (occ_q)
      OCC_EMPTY: begin
        if (s_fire) begin
          occ_d      = OCC_ONE;
          out_addr_d = S_AWADDR;
          out_prot_d = S_AWPROT;
        end
      end
      OCC_ONE: begin
        if (s_fire && !m_fire) begin
          // Downstream is stalled: park the younger entry in the skid reg.
          occ_d       = OCC_FULL;
          skid_addr_d = S_AWADDR;
          skid_prot_d = S_AWPROT;
        end else if (s_fire && m_fire) begin
          out_addr_d = S_AWADDR;
          out_prot_d = S_AWPROT;
        end else if (m_fire) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (m_fire) begin
          occ_d      = OCC_ONE;
          out_addr_d = skid_addr_q;
          out_prot_d = skid_prot_q;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase

    // Ready and valid are registered images of the next occupancy, so no
    // combinational path exists from either handshake input to an output.
    s_ready_d = (occ_d != OCC_FULL);
    m_valid_d = (occ_d != OCC_EMPTY);
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      occ_q       <= OCC_EMPTY;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      out_addr_q  <= '0;
      out_prot_q  <= '0;
      skid_addr_q <= '0;
      skid_prot_q <= '0;
    end else begin
      occ_q       <= occ_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      out_addr_q  <= out_addr_d;
      out_prot_q  <= out_prot_d;
      skid_addr_q <= skid_addr_d;
      skid_prot_q <= skid_prot_d;
    end
  end

  assign S_AWREADY = s_ready_q;
  assign M_AWVALID = m_valid_q;
  assign M_AWADDR  = out_addr_q;
  assign M_AWPROT  = out_prot_q;
  assign occupancy = occ_q;

  axil_stall_mon #(
    .MAXWAIT (MAXWAIT)
  ) u_stall_mon (
    .clk       (AXI_ACLK),
    .rst_n     (AXI_ARESETN),
    .valid     (m_valid_q),
    .ready     (M_AWREADY),
    .stall_err (stall_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_axil_aw_skid_slice.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_aw_skid_slice
//  Description : Self-checking bench for axil_aw_skid_slice. A reference
//                model treats the slice as a 2-deep FIFO with registered
//                ready and a consecutive-stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_aw_skid_slice;

  localparam int ADDR_W  = 32;
  localparam int PROT_W  = 3;
  localparam int MAXWAIT = 5;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] s_addr  = '0;
  logic [PROT_W-1:0] s_prot  = '0;
  logic              s_valid = 1'b0;
  logic              m_ready = 1'b0;
  wire               s_ready;
  wire  [ADDR_W-1:0] m_addr;
  wire  [PROT_W-1:0] m_prot;
  wire               m_valid;
  wire  [1:0]        occ;
  wire               serr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [ADDR_W+PROT_W-1:0] q[$];
  bit ready_m = 1'b0;
  int run     = 0;
  bit err_m   = 1'b0;

  always #5 clk = ~clk;

  axil_aw_skid_slice #(
    .ADDR_W  (ADDR_W),
    .PROT_W  (PROT_W),
    .MAXWAIT (MAXWAIT)
  ) dut (
    .AXI_ACLK    (clk),
    .AXI_ARESETN (rst_n),
    .S_AWADDR    (s_addr),
    .S_AWPROT    (s_prot),
    .S_AWVALID   (s_valid),
    .S_AWREADY   (s_ready),
    .M_AWADDR    (m_addr),
    .M_AWPROT    (m_prot),
    .M_AWVALID   (m_valid),
    .M_AWREADY   (m_ready),
    .occupancy   (occ),
    .stall_err   (serr)
  );

  // Advance one clock edge and update the model from the inputs driven
  // before the edge; returns 1 time unit after the edge.
  task automatic tick();
    bit sf, mf, mv;
    mv = (q.size() > 0);
    sf = s_valid && ready_m;
    mf = mv && m_ready;
    @(posedge clk);
    if (mf) void'(q.pop_front());
    if (sf) q.push_back({s_prot, s_addr});
    if (mv && !m_ready) run++;
    else run = 0;
    if (run >= MAXWAIT) err_m = 1'b1;
    ready_m = (q.size() < 2);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    q.delete();
    ready_m = 1'b0;
    run     = 0;
    err_m   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    s_addr  = 32'h0000_5555;
    s_prot  = 3'd5;
    m_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    q.delete();
    ready_m = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %b want 0", m_valid); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h want 0", m_addr); end
    checks++; if (m_prot !== 3'h0) begin errors++; $display("FAIL reset_mprot got %h want 0", m_prot); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ); end
    checks++; if (serr !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", serr); end
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL release_ready_pre got %b want 0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_ready_edge1 got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL release_mvalid_edge1 got %b want 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_addr !== 32'h5555 || m_prot !== 3'd5) begin
      errors++; $display("FAIL release_first_accept got v=%b a=%h p=%h want v=1 a=5555 p=5", m_valid, m_addr, m_prot);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL release_drain_occ got %0d want 0", occ); end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_addr  = 32'h1000 + 32'(i);
      s_prot  = 3'($urandom);
      tick();
      checks++; if (m_valid !== 1'b1 || m_addr !== 32'h1000 + 32'(i)) begin
        errors++; $display("FAIL stream_addr[%0d] got v=%b a=%h want v=1 a=%h", i, m_valid, m_addr, 32'h1000 + 32'(i));
      end
      checks++; if ({m_prot, m_addr} !== q[0]) begin errors++; $display("FAIL stream_payload[%0d] got %h want %h", i, {m_prot, m_addr}, q[0]); end
      checks++; if (occ !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occ); end
    end
    s_valid = 1'b0;
    tick();
    checks++; if (occ !== 2'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL stream_end got occ=%0d v=%b want occ=0 v=0", occ, m_valid); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    s_valid = 1'b1; s_addr = 32'hA0; s_prot = 3'd1;
    tick();
    s_addr = 32'hA4; s_prot = 3'd2;
    tick();
    s_valid = 1'b0;
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL bp_occ_full got %0d want 2", occ); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", s_ready); end
    repeat (2) tick();
    checks++; if (m_addr !== 32'hA0 || m_prot !== 3'd1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold got v=%b a=%h p=%h want v=1 a=a0 p=1", m_valid, m_addr, m_prot);
    end
    m_ready = 1'b1;
    tick();
    checks++; if (m_addr !== 32'hA4 || m_prot !== 3'd2) begin errors++; $display("FAIL bp_second got a=%h p=%h want a=a4 p=2", m_addr, m_prot); end
    checks++; if (s_ready !== 1'b1 || occ !== 2'd1) begin errors++; $display("FAIL bp_ready_back got rdy=%b occ=%0d want rdy=1 occ=1", s_ready, occ); end
    tick();
    checks++; if (occ !== 2'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got occ=%0d v=%b want 0 0", occ, m_valid); end
    checks++; if (serr !== 1'b0) begin errors++; $display("FAIL bp_no_err got %b want 0", serr); end
  endtask

  task automatic test_stall_err();
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_addr = 32'hC0; s_prot = 3'd0;
    tick();
    s_valid = 1'b0;
    for (int k = 1; k <= MAXWAIT; k++) begin
      tick();
      checks++; if (serr !== (k >= MAXWAIT)) begin errors++; $display("FAIL stall_err_edge[%0d] got %b want %b", k, serr, (k >= MAXWAIT)); end
    end
    m_ready = 1'b1;
    tick();
    checks++; if (serr !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL stall_err_sticky got err=%b v=%b want 1 0", serr, m_valid); end
    tick();
    checks++; if (serr !== 1'b1) begin errors++; $display("FAIL stall_err_idle got %b want 1", serr); end
    do_reset();
    checks++; if (serr !== 1'b0) begin errors++; $display("FAIL stall_err_reset got %b want 0", serr); end
  endtask

  task automatic test_stall_no_err();
    for (int r = 0; r < 3; r++) begin
      m_ready = 1'b0;
      s_valid = 1'b1; s_addr = 32'hD0 + 32'(r); s_prot = 3'(r);
      tick();
      s_valid = 1'b0;
      repeat (MAXWAIT - 1) tick();
      m_ready = 1'b1;
      tick();
      checks++; if (serr !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL stall_no_err[%0d] got err=%b occ=%0d want 0 0", r, serr, occ); end
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    s_valid = 1'b1; s_addr = 32'hB0; s_prot = 3'd3;
    tick();
    s_addr = 32'hB4; s_prot = 3'd4;
    tick();
    s_valid = 1'b0;
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL rmid_full got %0d want 2", occ); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL rmid_async got v=%b rdy=%b want 0 0", m_valid, s_ready); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rmid_occ got %0d want 0", occ); end
    q.delete(); ready_m = 1'b0; run = 0; err_m = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (m_valid !== 1'b0 || m_addr !== 32'h0) begin errors++; $display("FAIL rmid_no_ghost[%0d] got v=%b a=%h want 0 0", i, m_valid, m_addr); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom % 4) != 0;
      m_ready = ($urandom % 3) != 0;
      s_addr  = $urandom;
      s_prot  = 3'($urandom);
      tick();
      checks++; if (occ !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ[%0d] got %0d want %0d", c, occ, q.size()); end
      checks++; if (s_ready !== ready_m) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", c, s_ready, ready_m); end
      checks++; if (m_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", c, m_valid, (q.size() > 0)); end
      if (q.size() > 0) begin
        checks++; if ({m_prot, m_addr} !== q[0]) begin errors++; $display("FAIL rnd_payload[%0d] got %h want %h", c, {m_prot, m_addr}, q[0]); end
      end
      checks++; if (serr !== err_m) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", c, serr, err_m); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall_err();
    test_stall_no_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
